rd_credit_arbiter: RTL and testbench

//  Multi-channel read-request arbiter with per-channel credit/overflow guard; sits between N read engines and fiu.c0Tx.

---
 rtl/rd_credit_arbiter_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 60 ++++++
 rtl/rd_credit_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_rd_credit_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_credit_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rd_credit_arbiter_pkg
//  Description : Shared constants, channel-width helper and the per-channel
//                read request record for the credit-guarded read arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package rd_credit_arbiter_pkg;

    // Width of the CCI-P mdata field carried with every read request
    localparam int C_MDATA_W   = 16;
    // Width of a cache-line address (t_ccip_clAddr)
    localparam int C_CL_ADDR_W = 42;
    // Default tag prefix placed above the channel index in mdata
    localparam logic [15:0] C_MDATA_BASE_DEF = 16'hA0;

    // One read engine's request as seen by the arbiter
    typedef struct packed {
        logic                   valid;
        logic [C_CL_ADDR_W-1:0] addr;
    } t_rd_ch_req;

    // Bits needed to carry a channel index; never less than one bit
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : One-hot round-robin arbiter. The search starts at the
//                pointer and wraps at N; the pointer moves to the slot after
//                the winner only when something is granted.
//  Revision    : 1.0 - initial release
//  Ports       : clk    in  clock
//                rst_n  in  asynchronous reset, active low
//                i_req  in  N request lines
//                o_gnt  out N one-hot grant (combinational)
// ============================================================================
module rr_arbiter
    import rd_credit_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_gnt
);

    localparam int PTR_W = ch_w(N);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_d;
    logic             w_any;

    // (base + off) mod N for base < N and off <= N
    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= N) s = s - N;
        return s;
    endfunction

    always_comb begin
        w_any   = 1'b0;
        o_gnt   = '0;
        w_ptr_d = r_ptr;
        for (int i = 0; i < N; i++) begin
            if (!w_any && i_req[PTR_W'(wrap_idx(int'(r_ptr), i))]) begin
                o_gnt[PTR_W'(wrap_idx(int'(r_ptr), i))] = 1'b1;
                w_ptr_d = PTR_W'(wrap_idx(int'(r_ptr), i + 1));
                w_any   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= w_ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rd_credit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rd_credit_arbiter
//  Description : Multi-channel read-request arbiter for fiu.c0Tx. Tags mdata
//                with the channel, counts in-flight reads per channel, routes
//                c0Rx read responses back and stalls a channel whose in-flight
//                reads plus response-FIFO fill could overflow that FIFO.
//  Revision    : 1.0 - initial release
//  Ports       : clk, reset_n           clock, async active-low reset
//                enable                 grants allowed
//                req_valid/addr/ready   per-channel request handshake
//                fifo_count             per-channel response FIFO fill
//                tx_alm_full            c0Tx back-pressure
//                tx_valid/addr/mdata    registered read request to c0Tx
//                rx_rsp, rx_mdata       c0Rx read-response indication
//                rsp_valid, rsp_ch      registered response routing
//                busy                   reads in flight or request pending
//                err_underflow          sticky response-without-request flag
// ============================================================================
module rd_credit_arbiter
    import rd_credit_arbiter_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          ADDR_W     = 42,
    parameter int          CNT_W      = 16,
    parameter int          FIFO_DEPTH = 512,
    parameter int          ALM_BUFFER = 16,
    parameter logic [15:0] MDATA_BASE = C_MDATA_BASE_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         req_valid,
    input  logic [NUM_CH*ADDR_W-1:0]  req_addr,
    output logic [NUM_CH-1:0]         req_ready,
    input  logic [NUM_CH*CNT_W-1:0]   fifo_count,
    input  logic                      tx_alm_full,
    output logic                      tx_valid,
    output logic [ADDR_W-1:0]         tx_addr,
    output logic [C_MDATA_W-1:0]      tx_mdata,
    input  logic                      rx_rsp,
    input  logic [C_MDATA_W-1:0]      rx_mdata,
    output logic                      rsp_valid,
    output logic [ch_w(NUM_CH)-1:0]   rsp_ch,
    output logic                      busy,
    output logic                      err_underflow
);

    localparam int CH_W  = ch_w(NUM_CH);
    localparam int TAG_W = C_MDATA_W - CH_W;

    localparam logic [CNT_W:0]     c_risk_thr = (CNT_W+1)'(FIFO_DEPTH - ALM_BUFFER);
    localparam logic [TAG_W-1:0]   c_tag      = MDATA_BASE[TAG_W-1:0];
    localparam logic [CH_W:0]      c_num_ch   = (CH_W+1)'(NUM_CH);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_busy = 1'b1;

    if (ALM_BUFFER < 4) begin : g_alm_check
        $error("rd_credit_arbiter: ALM_BUFFER must be at least 4");
    end

    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_gnt;
    logic [NUM_CH-1:0] w_risk;
    logic [NUM_CH-1:0] w_dec;
    logic [NUM_CH-1:0] w_uflow;
    logic [NUM_CH-1:0] w_cnt_nz_d;
    logic [CH_W-1:0]   w_gnt_idx;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [CH_W-1:0]   w_rx_ch;
    logic              w_rx_hit;
    logic              w_gate;
    logic              w_busy_d;
    logic [0:0]        w_state_d;

    logic                 r_tx_valid;
    logic [ADDR_W-1:0]    r_tx_addr;
    logic [C_MDATA_W-1:0] r_tx_mdata;
    logic                 r_rsp_valid;
    logic [CH_W-1:0]      r_rsp_ch;
    logic                 r_err;
    logic [0:0]           r_state;

    // reset_n is part of the gate so req_ready reads 0 while reset is held,
    // even when the engines keep their requests asserted.
    assign w_gate = reset_n & enable & ~tx_alm_full;
    assign w_elig = {NUM_CH{w_gate}} & req_valid & ~w_risk;

    rr_arbiter #(.N(NUM_CH)) u_rr (
        .clk   (clk),
        .rst_n (reset_n),
        .i_req (w_elig),
        .o_gnt (w_gnt)
    );

    assign req_ready = w_gnt;

    always_comb begin
        w_gnt_idx  = '0;
        w_gnt_addr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx  = CH_W'(i);
                w_gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Responses carrying any other mdata (control reads etc.) are not ours.
    assign w_rx_ch  = rx_mdata[CH_W-1:0];
    assign w_rx_hit = rx_rsp && (rx_mdata[C_MDATA_W-1:CH_W] == c_tag) &&
                      ({1'b0, w_rx_ch} < c_num_ch);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_d;
        logic [CNT_W:0]   r_s1;
        logic             r_risk;

        assign w_dec[c]   = w_rx_hit && (w_rx_ch == CH_W'(c));
        assign w_uflow[c] = w_dec[c] && !w_gnt[c] && (r_cnt == '0);

        // Grant and response on the same channel cancel out.
        always_comb begin
            w_cnt_d = r_cnt;
            if (w_gnt[c] && !w_dec[c]) begin
                w_cnt_d = r_cnt + CNT_W'(1);
            end else if (!w_gnt[c] && w_dec[c] && (r_cnt != '0)) begin
                w_cnt_d = r_cnt - CNT_W'(1);
            end
        end

        assign w_cnt_nz_d[c] = (w_cnt_d != '0);
        assign w_risk[c]     = r_risk;

        // Two-stage risk pipeline; ALM_BUFFER absorbs grants issued while a
        // new count is still travelling toward r_risk.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt  <= '0;
                r_s1   <= '0;
                r_risk <= 1'b0;
            end else begin
                r_cnt  <= w_cnt_d;
                r_s1   <= {1'b0, r_cnt} + {1'b0, fifo_count[c*CNT_W +: CNT_W]};
                r_risk <= (r_s1 > c_risk_thr);
            end
        end
    end

    assign w_busy_d = (|w_gnt) | (|w_cnt_nz_d);

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            c_st_idle: if (w_busy_d)  w_state_d = c_st_busy;
            c_st_busy: if (!w_busy_d) w_state_d = c_st_idle;
            default:                  w_state_d = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_valid  <= 1'b0;
            r_tx_addr   <= '0;
            r_tx_mdata  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_ch    <= '0;
            r_err       <= 1'b0;
            r_state     <= c_st_idle;
        end else begin
            r_tx_valid <= |w_gnt;
            if (|w_gnt) begin
                r_tx_addr  <= w_gnt_addr;
                r_tx_mdata <= {c_tag, w_gnt_idx};
            end
            r_rsp_valid <= w_rx_hit;
            if (w_rx_hit) begin
                r_rsp_ch <= w_rx_ch;
            end
            r_err   <= r_err | (|w_uflow);
            r_state <= w_state_d;
        end
    end

    assign tx_valid      = r_tx_valid;
    assign tx_addr       = r_tx_addr;
    assign tx_mdata      = r_tx_mdata;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_ch        = r_rsp_ch;
    assign err_underflow = r_err;
    assign busy          = (r_state == c_st_busy);

endmodule
`default_nettype wire

// File: tb/tb_rd_credit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rd_credit_arbiter
//  Description : Directed bench for rd_credit_arbiter. Stimulus pushes the
//                expected c0Tx requests and routed responses into queues; a
//                monitor pops and compares whenever the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rd_credit_arbiter;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 42;
    localparam int CNT_W  = 16;

    logic                     clk         = 1'b0;
    logic                     reset_n     = 1'b1;
    logic                     enable      = 1'b0;
    logic [NUM_CH-1:0]        req_valid   = '0;
    logic [NUM_CH*ADDR_W-1:0] req_addr    = '0;
    logic [NUM_CH*CNT_W-1:0]  fifo_count  = '0;
    logic                     tx_alm_full = 1'b0;
    logic                     rx_rsp      = 1'b0;
    logic [15:0]              rx_mdata    = '0;
    logic [NUM_CH-1:0]        req_ready;
    logic                     tx_valid;
    logic [ADDR_W-1:0]        tx_addr;
    logic [15:0]              tx_mdata;
    logic                     rsp_valid;
    logic [1:0]               rsp_ch;
    logic                     busy;
    logic                     err_underflow;

    rd_credit_arbiter #(
        .NUM_CH(4), .ADDR_W(42), .CNT_W(16),
        .FIFO_DEPTH(512), .ALM_BUFFER(16), .MDATA_BASE(16'hA0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .fifo_count(fifo_count), .tx_alm_full(tx_alm_full),
        .tx_valid(tx_valid), .tx_addr(tx_addr), .tx_mdata(tx_mdata),
        .rx_rsp(rx_rsp), .rx_mdata(rx_mdata),
        .rsp_valid(rsp_valid), .rsp_ch(rsp_ch),
        .busy(busy), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       mdata;
    } t_tx_exp;

    t_tx_exp     q_tx[$];
    logic [1:0]  q_rsp[$];
    t_tx_exp     mon_e;
    logic [1:0]  mon_ch;
    logic [ADDR_W-1:0] addr_base = '0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [ADDR_W-1:0] addr_of(input int c);
        return addr_base + ADDR_W'(c) * ADDR_W'(64) + ADDR_W'(5);
    endfunction

    task automatic set_addrs(input logic [ADDR_W-1:0] base);
        addr_base = base;
        for (int c = 0; c < NUM_CH; c++) req_addr[c*ADDR_W +: ADDR_W] = addr_of(c);
    endtask

    // One clock of stimulus. exp_rdy is the hand-derived grant; exp_hit says
    // whether the response in this cycle belongs to the arbiter.
    task automatic cyc(input logic [3:0] v, input logic [3:0] exp_rdy,
                       input logic rx, input logic [15:0] md, input logic exp_hit);
        t_tx_exp e;
        req_valid = v;
        rx_rsp    = rx;
        rx_mdata  = md;
        #2;
        chk("req_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
        for (int c = 0; c < NUM_CH; c++) begin
            if (exp_rdy[c]) begin
                e.addr  = addr_of(c);
                e.mdata = 16'h0280 | 16'(c);
                q_tx.push_back(e);
            end
        end
        if (exp_hit) q_rsp.push_back(md[1:0]);
        @(posedge clk);
        #1;
        rx_rsp = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset_n) begin
            if (tx_valid) begin
                if (q_tx.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL tx_unexpected: got addr %0h mdata %0h expected none", tx_addr, tx_mdata);
                end else begin
                    mon_e = q_tx.pop_front();
                    chk("tx_addr", 64'(tx_addr), 64'(mon_e.addr));
                    chk("tx_mdata", 64'(tx_mdata), 64'(mon_e.mdata));
                end
            end
            if (rsp_valid) begin
                if (q_rsp.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL rsp_unexpected: got ch %0d expected none", rsp_ch);
                end else begin
                    mon_ch = q_rsp.pop_front();
                    chk("rsp_ch", 64'(rsp_ch), 64'(mon_ch));
                end
            end
        end
    end

    initial begin
        set_addrs(42'h10000);
        #1 reset_n = 1'b0;
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_tx_addr", 64'(tx_addr), 64'd0);
        chk("rst_tx_mdata", 64'(tx_mdata), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_ch", 64'(rsp_ch), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_underflow), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        enable  = 1'b1;

        // 1: all channels requesting -> 0,1,2,3,0
        cyc(4'hF, 4'b0001, 0, 16'h0, 0);
        cyc(4'hF, 4'b0010, 0, 16'h0, 0);
        cyc(4'hF, 4'b0100, 0, 16'h0, 0);
        cyc(4'hF, 4'b1000, 0, 16'h0, 0);
        cyc(4'hF, 4'b0001, 0, 16'h0, 0);
        cyc(4'h0, 4'b0000, 0, 16'h0, 0);
        chk("t1_busy", 64'(busy), 64'd1);
        // drain 0,0,1,2,3
        cyc(4'h0, 4'b0000, 1, 16'h0280, 1);
        cyc(4'h0, 4'b0000, 1, 16'h0280, 1);
        cyc(4'h0, 4'b0000, 1, 16'h0281, 1);
        cyc(4'h0, 4'b0000, 1, 16'h0282, 1);
        cyc(4'h0, 4'b0000, 1, 16'h0283, 1);
        chk("t1_busy_drained", 64'(busy), 64'd0);
        chk("t1_err", 64'(err_underflow), 64'd0);

        // 2: ch1 at 495 lines; after its second grant it must be skipped
        set_addrs(42'h2_0000_0000);
        fifo_count[1*CNT_W +: CNT_W] = 16'd495;
        cyc(4'hF, 4'b0010, 0, 16'h0, 0);
        cyc(4'hF, 4'b0100, 0, 16'h0, 0);
        cyc(4'hF, 4'b1000, 0, 16'h0, 0);
        cyc(4'hF, 4'b0001, 0, 16'h0, 0);
        cyc(4'hF, 4'b0010, 0, 16'h0, 0);
        cyc(4'hF, 4'b0100, 0, 16'h0, 0);
        cyc(4'hF, 4'b1000, 0, 16'h0, 0);
        cyc(4'hF, 4'b0001, 0, 16'h0, 0);
        cyc(4'hF, 4'b0100, 0, 16'h0, 0);
        cyc(4'hF, 4'b1000, 0, 16'h0, 0);
        cyc(4'hF, 4'b0001, 0, 16'h0, 0);
        cyc(4'hF, 4'b0100, 0, 16'h0, 0);
        cyc(4'b0010, 4'b0000, 0, 16'h0, 0);

        // 3: tx_alm_full holds everything, then resumes at pointer 3
        tx_alm_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(4'hF, 4'b0000, 0, 16'h0, 0);
            chk("t3_tx_valid", 64'(tx_valid), 64'd0);
        end
        tx_alm_full = 1'b0;
        cyc(4'hF, 4'b1000, 0, 16'h0, 0);
        cyc(4'hF, 4'b0001, 0, 16'h0, 0);
        fifo_count = '0;
        cyc(4'h0, 4'b0000, 0, 16'h0, 0);
        // in flight now: ch0=4 ch1=2 ch2=4 ch3=4

        // 4: ch2 down to 3, then grant+response on ch2 together
        cyc(4'h0, 4'b0000, 1, 16'h0282, 1);
        cyc(4'b0100, 4'b0100, 1, 16'h0282, 1);

        // 5: foreign mdata ignored; exact drain then one extra response
        cyc(4'h0, 4'b0000, 1, 16'h0000, 0);
        chk("t5_ctrl_rsp_valid", 64'(rsp_valid), 64'd0);
        cyc(4'h0, 4'b0000, 1, 16'h1281, 0);
        chk("t5_tag_rsp_valid", 64'(rsp_valid), 64'd0);
        for (int i = 0; i < 4; i++) cyc(4'h0, 4'b0000, 1, 16'h0280, 1);
        for (int i = 0; i < 2; i++) cyc(4'h0, 4'b0000, 1, 16'h0281, 1);
        for (int i = 0; i < 3; i++) cyc(4'h0, 4'b0000, 1, 16'h0282, 1);
        for (int i = 0; i < 3; i++) cyc(4'h0, 4'b0000, 1, 16'h0283, 1);
        chk("t5_busy_before_last", 64'(busy), 64'd1);
        cyc(4'h0, 4'b0000, 1, 16'h0283, 1);
        chk("t5_busy_drained", 64'(busy), 64'd0);
        chk("t5_err_clean", 64'(err_underflow), 64'd0);
        cyc(4'h0, 4'b0000, 1, 16'h0281, 1);
        chk("t5_err_underflow", 64'(err_underflow), 64'd1);
        chk("t5_busy_after_uflow", 64'(busy), 64'd0);

        // 6a: three in flight, enable drops, busy holds until drained
        cyc(4'hF, 4'b1000, 0, 16'h0, 0);
        cyc(4'hF, 4'b0001, 0, 16'h0, 0);
        cyc(4'hF, 4'b0010, 0, 16'h0, 0);
        enable = 1'b0;
        cyc(4'hF, 4'b0000, 0, 16'h0, 0);
        chk("t6_busy_3", 64'(busy), 64'd1);
        cyc(4'hF, 4'b0000, 1, 16'h0283, 1);
        chk("t6_busy_2", 64'(busy), 64'd1);
        cyc(4'hF, 4'b0000, 1, 16'h0280, 1);
        chk("t6_busy_1", 64'(busy), 64'd1);
        cyc(4'hF, 4'b0000, 1, 16'h0281, 1);
        chk("t6_busy_0", 64'(busy), 64'd0);
        chk("t6_err_sticky", 64'(err_underflow), 64'd1);

        // 6b: seven in flight, asynchronous reset mid-operation
        enable = 1'b1;
        cyc(4'hF, 4'b0100, 0, 16'h0, 0);
        cyc(4'hF, 4'b1000, 0, 16'h0, 0);
        cyc(4'hF, 4'b0001, 0, 16'h0, 0);
        cyc(4'hF, 4'b0010, 0, 16'h0, 0);
        cyc(4'hF, 4'b0100, 0, 16'h0, 0);
        cyc(4'hF, 4'b1000, 0, 16'h0, 0);
        cyc(4'hF, 4'b0001, 0, 16'h0, 0);
        #5;
        reset_n = 1'b0;
        #1;
        chk("t6r_req_ready", 64'(req_ready), 64'd0);
        chk("t6r_tx_valid", 64'(tx_valid), 64'd0);
        chk("t6r_tx_addr", 64'(tx_addr), 64'd0);
        chk("t6r_tx_mdata", 64'(tx_mdata), 64'd0);
        chk("t6r_busy", 64'(busy), 64'd0);
        chk("t6r_err", 64'(err_underflow), 64'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        reset_n   = 1'b1;
        // late response after reset counts as underflow
        cyc(4'h0, 4'b0000, 1, 16'h0282, 1);
        chk("t6r_late_err", 64'(err_underflow), 64'd1);
        chk("t6r_late_busy", 64'(busy), 64'd0);
        // pointer restarted at 0
        cyc(4'hF, 4'b0001, 0, 16'h0, 0);
        cyc(4'h0, 4'b0000, 0, 16'h0, 0);
        cyc(4'h0, 4'b0000, 0, 16'h0, 0);

        chk("end_tx_queue_empty", 64'(q_tx.size()), 64'd0);
        chk("end_rsp_queue_empty", 64'(q_rsp.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
